// File: rtl/prim_clock_div_multi_if.sv
// Control/status bundle for prim_clock_div_multi: per-channel enable, ratio
// request/ack handshake, scan select and the divided clock/tick outputs.
interface prim_clock_div_multi_if #(
    parameter int unsigned NumChan  = 2,
    parameter int unsigned CntWidth = 8
);
    logic                         scanmode_i;
    logic [NumChan-1:0]           en_i;
    logic [NumChan*CntWidth-1:0]  div_i;
    logic [NumChan-1:0]           div_req_i;
    logic [NumChan-1:0]           div_ack_o;
    logic [NumChan-1:0]           clk_o;
    logic [NumChan-1:0]           tick_o;

    modport master (
        output scanmode_i, en_i, div_i, div_req_i,
        input  div_ack_o, clk_o, tick_o
    );

    modport slave (
        input  scanmode_i, en_i, div_i, div_req_i,
        output div_ack_o, clk_o, tick_o
    );
endinterface

// File: rtl/prim_clock_div_multi.sv
// Multi-channel glitch-free programmable clock divider with scan bypass.
// Optional macro PRIM_CLOCK_DIV_BUFG_EN routes each clk_o through a BUFG.
module prim_clock_div_multi #(
    parameter int unsigned NumChan     = 2,
    parameter int unsigned CntWidth    = 8,
    parameter int unsigned ResetDiv    = 2,
    parameter bit          HasScanMode = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    prim_clock_div_multi_if.slave bus
);
    localparam logic [CntWidth-1:0] MinDiv   = CntWidth'(2);
    localparam logic [CntWidth-1:0] ResetVal = CntWidth'(ResetDiv);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StStop = 2'd2
    } state_e;

    state_e              state_q [NumChan];
    state_e              state_d [NumChan];
    logic [CntWidth-1:0] cnt_q   [NumChan];
    logic [CntWidth-1:0] cnt_d   [NumChan];
    logic [CntWidth-1:0] div_q   [NumChan];
    logic [CntWidth-1:0] div_d   [NumChan];
    logic [CntWidth-1:0] req_div [NumChan];

    logic [NumChan-1:0] clk_q, clk_d;
    logic [NumChan-1:0] tick_q, tick_d;
    logic [NumChan-1:0] ack_q, ack_d;
    logic [NumChan-1:0] req_vld, wrap;
    logic [NumChan-1:0] clk_mux;
    logic               scan_en;

    assign scan_en = HasScanMode && bus.scanmode_i;

    // The ack cycle itself is not a new request; a request held beyond it is.
    assign req_vld = bus.div_req_i & ~ack_q;

    // Requested ratios below 2 are clamped; boundary is the last count of a period.
    always_comb begin
        for (int n = 0; n < NumChan; n++) begin
            req_div[n] = bus.div_i[n*CntWidth +: CntWidth];
            if (req_div[n] < MinDiv) begin
                req_div[n] = MinDiv;
            end
            wrap[n] = (cnt_q[n] == (div_q[n] - CntWidth'(1)));
        end
    end

    // Per-channel next state; ratio changes only land on a period boundary or in idle.
    always_comb begin
        for (int n = 0; n < NumChan; n++) begin
            state_d[n] = state_q[n];
            cnt_d[n]   = cnt_q[n];
            div_d[n]   = div_q[n];
            ack_d[n]   = 1'b0;

            unique case (state_q[n])
                StIdle: begin
                    cnt_d[n] = '0;
                    if (req_vld[n]) begin
                        div_d[n] = req_div[n];
                        ack_d[n] = 1'b1;
                    end
                    if (bus.en_i[n]) begin
                        state_d[n] = StRun;
                    end
                end
                StRun, StStop: begin
                    if (wrap[n]) begin
                        cnt_d[n] = '0;
                        if (req_vld[n]) begin
                            div_d[n] = req_div[n];
                            ack_d[n] = 1'b1;
                        end
                        state_d[n] = bus.en_i[n] ? StRun : StIdle;
                    end else begin
                        cnt_d[n]   = cnt_q[n] + CntWidth'(1);
                        state_d[n] = bus.en_i[n] ? StRun : StStop;
                    end
                end
                default: begin
                    state_d[n] = StIdle;
                    cnt_d[n]   = '0;
                end
            endcase

            clk_d[n]  = (state_d[n] != StIdle) && (cnt_d[n] < (div_d[n] >> 1));
            tick_d[n] = (state_d[n] != StIdle) && (cnt_d[n] == '0) && !scan_en;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int n = 0; n < NumChan; n++) begin
                state_q[n] <= StIdle;
                cnt_q[n]   <= '0;
                div_q[n]   <= ResetVal;
            end
            clk_q  <= '0;
            tick_q <= '0;
            ack_q  <= '0;
        end else begin
            for (int n = 0; n < NumChan; n++) begin
                state_q[n] <= state_d[n];
                cnt_q[n]   <= cnt_d[n];
                div_q[n]   <= div_d[n];
            end
            clk_q  <= clk_d;
            tick_q <= tick_d;
            ack_q  <= ack_d;
        end
    end

    // Scan bypass sits after the divider flop so internal phase keeps advancing.
    assign clk_mux = scan_en ? {NumChan{clk_i}} : clk_q;

`ifdef PRIM_CLOCK_DIV_BUFG_EN
    for (genvar n = 0; n < NumChan; n++) begin : g_bufg
        BUFG u_bufg (
            .I (clk_mux[n]),
            .O (bus.clk_o[n])
        );
    end
`else
    assign bus.clk_o = clk_mux;
`endif

    assign bus.tick_o    = tick_q;
    assign bus.div_ack_o = ack_q;

endmodule

// File: tb/tb_prim_clock_div_multi.sv
// Self-checking bench for prim_clock_div_multi: directed plan plus random
// enable/ratio traffic against a period-arithmetic reference model.
module tb_prim_clock_div_multi;
    localparam int unsigned NC  = 2;
    localparam int unsigned CW  = 8;
    localparam int unsigned RDV = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prim_clock_div_multi_if #(.NumChan(NC), .CntWidth(CW)) bus ();

    prim_clock_div_multi #(
        .NumChan(NC), .CntWidth(CW), .ResetDiv(RDV), .HasScanMode(1'b1)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Model: a channel is either producing clocks or not; phase is derived from
    // the cycle at which the current period began, modulo the active ratio.
    longint cyc = 0;
    bit     m_active [NC];
    int     m_d      [NC];
    longint m_base   [NC];
    bit     m_ack    [NC];
    bit     m_clk    [NC];
    bit     m_tick   [NC];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_step();
        for (int n = 0; n < NC; n++) begin
            bit  req;
            int  nd;
            longint ph;
            req = bus.div_req_i[n] && !m_ack[n];
            nd  = int'(bus.div_i[n*CW +: CW]);
            if (nd < 2) nd = 2;
            if (rst) begin
                m_active[n] = 1'b0;
                m_d[n]      = RDV;
                m_ack[n]    = 1'b0;
            end else if (!m_active[n]) begin
                m_ack[n] = req;
                if (req) m_d[n] = nd;
                if (bus.en_i[n]) begin
                    m_active[n] = 1'b1;
                    m_base[n]   = cyc + 1;
                end
            end else begin
                ph = (cyc - m_base[n]) % m_d[n];
                if (ph == longint'(m_d[n] - 1)) begin
                    m_ack[n] = req;
                    if (req) m_d[n] = nd;
                    if (bus.en_i[n]) m_base[n] = cyc + 1;
                    else m_active[n] = 1'b0;
                end else begin
                    m_ack[n] = 1'b0;
                end
            end
            if (m_active[n]) begin
                ph = (cyc + 1 - m_base[n]) % m_d[n];
                m_clk[n]  = ph < longint'(m_d[n] / 2);
                m_tick[n] = (ph == 0) && !(rst) && !bus.scanmode_i;
            end else begin
                m_clk[n]  = 1'b0;
                m_tick[n] = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic check_all();
        for (int n = 0; n < NC; n++) begin
            chk($sformatf("clk%0d", n),  32'(bus.clk_o[n]),
                bus.scanmode_i ? 32'd1 : 32'(m_clk[n]));
            chk($sformatf("tick%0d", n), 32'(bus.tick_o[n]),    32'(m_tick[n]));
            chk($sformatf("ack%0d", n),  32'(bus.div_ack_o[n]), 32'(m_ack[n]));
        end
    endtask

    // One clock: model consumes the inputs present at the edge, then compare.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        for (int n = 0; n < NC; n++) begin
            if (m_ack[n]) bus.div_req_i[n] = 1'b0;
        end
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) cycle();
    endtask

    function automatic longint phase(input int n);
        return (cyc - m_base[n]) % m_d[n];
    endfunction

    task automatic req_div(input int n, input int val);
        bit got;
        got = 1'b0;
        bus.div_i[n*CW +: CW] = CW'(val);
        bus.div_req_i[n]      = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            cycle();
            got = m_ack[n];
        end
        chk($sformatf("ack_timeout%0d", n), 32'(got), 32'd1);
    endtask

    task automatic wait_phase(input int n, input int ph);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            cycle();
            hit = m_active[n] && (phase(n) == longint'(ph));
        end
        chk($sformatf("phase_timeout%0d", n), 32'(hit), 32'd1);
    endtask

    initial begin
        for (int n = 0; n < NC; n++) begin
            m_active[n] = 1'b0; m_d[n] = RDV; m_base[n] = 0;
            m_ack[n] = 1'b0; m_clk[n] = 1'b0; m_tick[n] = 1'b0;
        end
        bus.scanmode_i = 1'b0;
        bus.en_i       = '0;
        bus.div_i      = '0;
        bus.div_req_i  = '0;

        // Reset state
        run(3);
        rst = 1'b0;
        run(2);

        // D = 2 from reset: 1,0,1,0 starting the cycle after enable
        bus.en_i[0] = 1'b1;
        run(8);

        // Ratio 4, then 5 requested while running: lands on a wrap
        req_div(0, 4);
        run(8);
        req_div(0, 5);
        run(12);

        // Stop at cnt = 1 with D = 6: period completes, then idle
        req_div(0, 6);
        wait_phase(0, 1);
        bus.en_i[0] = 1'b0;
        run(12);

        // D = 0 requested in idle: clamped to 2, one-cycle ack
        req_div(0, 0);
        bus.en_i[0] = 1'b1;
        run(8);

        // Re-enable during stop returns to run undisturbed
        req_div(0, 7);
        wait_phase(0, 2);
        bus.en_i[0] = 1'b0;
        run(2);
        bus.en_i[0] = 1'b1;
        run(12);

        // Random traffic on both channels
        for (int i = 0; i < 400; i++) begin
            for (int n = 0; n < NC; n++) begin
                if ($urandom_range(0, 15) == 0) bus.en_i[n] = ~bus.en_i[n];
                if (!bus.div_req_i[n] && $urandom_range(0, 9) == 0) begin
                    bus.div_i[n*CW +: CW] = CW'($urandom_range(0, 12));
                    bus.div_req_i[n]      = 1'b1;
                end
            end
            cycle();
        end
        bus.div_req_i = '0;
        bus.en_i      = '1;
        req_div(0, 4);
        req_div(1, 7);
        run(4);

        // Scan bypass mid-run, then release at the model phase
        bus.scanmode_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            @(negedge clk);
            #1;
            chk("scan_low", 32'(bus.clk_o), 32'd0);
        end
        bus.scanmode_i = 1'b0;
        run(10);

        // Reset mid-high-phase with a pending request on channel 1
        wait_phase(0, 0);
        bus.div_i[1*CW +: CW] = CW'(9);
        bus.div_req_i[1]      = 1'b1;
        rst = 1'b1;
        cycle();
        chk("rst_clk", 32'(bus.clk_o), 32'd0);
        rst = 1'b0;
        bus.div_req_i = '0;
        run(12);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/prim_clock_div_multi.md
# prim_clock_div_multi

Multi-channel programmable clock divider primitive, the next generation of the single-inverter clock primitive. Derives `NumChan` glitch-free divided clocks from one source clock, each with its own runtime divide ratio, enable and request/acknowledge handshake for ratio changes. Scan mode bypasses every channel to the source clock. It sits in the clock-generation layer, feeding slow peripheral domains such as USB PHY sampling and fabric config clocks.

## Interface
- `NumChan`, 2, number of independent divider channels (1..8)
- `CntWidth`, 8, divide-ratio and counter width
- `ResetDiv`, 2, divide ratio loaded at reset (2..2^CntWidth-1)
- `HasScanMode`, 1'b1, enables the scan bypass mux; when 0, `scanmode_i` is ignored
- `clk_i` input 1: source clock, all logic on its rising edge
- `rst_i` input 1: reset, synchronous, active-high
- `scanmode_i` input 1: scan bypass
- `en_i` input NumChan: per-channel run enable
- `div_i` input NumChan*CntWidth: requested ratio D; channel n uses bits [n*CntWidth +: CntWidth]
- `div_req_i` input NumChan: per-channel ratio-change request (level)
- `div_ack_o` output NumChan: one-cycle acknowledge; new ratio is active that cycle
- `clk_o` output NumChan: divided clock
- `tick_o` output NumChan: one-cycle strobe at each `clk_o` rising edge

## Operation
- Per channel: active ratio `D`, counter `cnt` (0..D-1), registered `clk_q`, state IDLE/RUN/STOP.
- `H = floor(D/2)`. In RUN, `clk_q = 1` while `cnt < H`, else 0. Period is D cycles; high H cycles, low D-H. Even D gives 50% duty; odd D gives one extra low cycle.
- `tick_o` is registered and high exactly when `cnt == 0` in RUN or STOP. It is forced 0 in scan mode.
- IDLE: `cnt = 0` and `clk_q = 0`. If `en_i = 1`, the state goes to RUN.
- RUN: `cnt` increments and wraps from D-1 to 0. If `en_i` falls, the state goes to STOP.
- STOP: the current period completes. At `cnt == D-1` the state goes to IDLE. If `en_i` rises again before then, the state returns to RUN with no disturbance. Truncated pulses never occur.
- Ratio change:
  - The requester holds `div_req_i = 1` with `div_i` stable until `div_ack_o` pulses.
  - In IDLE the new value loads on the next cycle.
  - In RUN or STOP the new value loads at the wrap boundary (`cnt == D-1`, so the next `cnt = 0` uses the new D).
  - `div_ack_o` pulses the cycle the new D is active.
  - `div_req_i` still high after the ack counts as a fresh request.
- Requested D < 2 is clamped to 2. It is still acknowledged.
- Simultaneous boundary, `en_i` low and pending request: the ratio loads, ack pulses, and the state goes to IDLE.
- Scan mode (`HasScanMode` and `scanmode_i = 1`):
  - `clk_o[n] = clk_i` combinationally for all channels.
  - Internal state keeps running, so de-asserting scan resumes the registered `clk_q`.
- Reset: `cnt = 0`, `clk_q = 0`, `D = ResetDiv`, state IDLE, `tick_o = 0`, `div_ack_o = 0`. Reset mid-period drives `clk_o` low on the next edge. A pending request is dropped.

## Timing
- `en_i` rises at cycle t in IDLE → `clk_o` and `tick_o` high at t+1. The first period is exactly D cycles.
- `en_i` falls mid-period → `clk_o` completes the period, low from the boundary. The latency of the stop is at most D cycles.
- Ratio-change latency: 1 cycle in IDLE; at most D_old cycles in RUN or STOP.
- `clk_o` outside scan mode is the direct output of a flop, with no combinational path from `en_i` or `div_i`.
- Channels are fully independent, with no cross-channel phase relation except a common reset.

## Configuration
- `PRIM_CLOCK_DIV_BUFG_EN` defined: each `clk_o[n]` is driven through a `BUFG` instance placed after the scan mux, for global clock routing.
- Not defined: `clk_o[n]` is assigned directly from the scan mux, for simulation and ASIC flows. Cycle behaviour is identical.

## Test plan
- Reset, then `en_i[0] = 1` with D = 2 → `clk_o[0]` is 1,0,1,0… starting one cycle after enable, and `tick_o[0]` pulses every 2 cycles.
- `div_i` = 5 with a request while running at D = 4 → ack at the next wrap, then 2 high / 3 low, with no pulse shorter than 2 cycles.
- Drop `en_i` at `cnt = 1` with D = 6 → high phase finishes, low through `cnt = 5`, then IDLE with `clk_o = 0` and no further ticks.
- Request D = 0 → ack pulses, period is 2.
- `scanmode_i = 1` mid-run → `clk_o == clk_i` on all channels and `tick_o = 0`. Release → the divided clock resumes at the correct counter phase.
- `rst_i` pulse mid-high-phase with channel 1 also running at D = 7 → both `clk_o` low next cycle, `D = ResetDiv`, pending request with no ack.
